// File: rtl/rv32i_decode_stage.sv
// Multi-lane registered RV32I decode stage with a skid buffer.
// Each lane produces a control word, branch select, immediate, illegal flag and RAW flag.
module rv32i_decode_stage #(
  parameter int LANES      = 2,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [32*LANES-1:0]     in_instr,
  input  logic [XLEN*LANES-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [XLEN*LANES-1:0]   out_pc,
  output logic [26*LANES-1:0]     out_control_word,
  output logic [3*LANES-1:0]      out_branch_sel,
  output logic [XLEN*LANES-1:0]   out_imm,
  output logic [LANES-1:0]        out_illegal,
  output logic [LANES-1:0]        out_dep
);

  localparam int BW = LANES * (1 + XLEN + 26 + 3 + XLEN + 1 + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b010;
  localparam logic [2:0] BR_NE   = 3'b011;
  localparam logic [2:0] BR_LT   = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;
  localparam logic [2:0] BR_JAL  = 3'b110;
  localparam logic [2:0] BR_JALR = 3'b111;

  logic [XLEN*LANES-1:0]       dec_pc;
  logic [26*LANES-1:0]         dec_cw;
  logic [3*LANES-1:0]          dec_bsel;
  logic [XLEN*LANES-1:0]       dec_imm;
  logic [LANES-1:0]            dec_ill;
  logic [LANES-1:0]            dec_dep;
  logic [LANES-1:0]            prod;
  logic [LANES-1:0]            use1;
  logic [LANES-1:0]            use2;
  logic [REG_ADDR_W*LANES-1:0] prod_rd;
  logic [REG_ADDR_W*LANES-1:0] src1;
  logic [REG_ADDR_W*LANES-1:0] src2;
  logic [BW-1:0]               dec_bundle;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0] instr;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        legal;
      logic        we;
      logic        save_pc;
      logic        load;
      logic        use_imm;
      logic        rs1_en;
      logic        rs2_en;
      logic        live;
      logic [3:0]  alu;
      logic [2:0]  mw;
      logic [2:0]  bsel;
      logic [31:0] imm32;

      assign instr  = in_instr[32*gi +: 32];
      assign opcode = instr[6:0];
      assign f3     = instr[14:12];
      assign rd     = instr[11:7];
      assign rs1    = instr[19:15];
      assign rs2    = instr[24:20];

      always_comb begin
        legal   = 1'b1;
        we      = 1'b0;
        save_pc = 1'b0;
        load    = 1'b0;
        use_imm = 1'b0;
        rs1_en  = 1'b1;
        rs2_en  = 1'b0;
        alu     = ALU_ADD;
        mw      = 3'b000;
        bsel    = BR_NONE;
        imm32   = 32'd0;
        case (opcode)
          OP_R: begin
            we     = 1'b1;
            rs2_en = 1'b1;
            case (f3)
              3'b000:  alu = instr[30] ? ALU_SUB : ALU_ADD;
              3'b001:  alu = ALU_SLL;
              3'b010:  alu = ALU_SLT;
              3'b011:  alu = ALU_SLTU;
              3'b100:  alu = ALU_XOR;
              3'b101:  alu = instr[30] ? ALU_SRA : ALU_SRL;
              3'b110:  alu = ALU_OR;
              default: alu = ALU_AND;
            endcase
          end
          OP_I: begin
            we      = 1'b1;
            use_imm = 1'b1;
            imm32   = {{20{instr[31]}}, instr[31:20]};
          end
          OP_LOAD: begin
            we      = 1'b1;
            load    = 1'b1;
            use_imm = 1'b1;
            mw      = f3;
            imm32   = {{20{instr[31]}}, instr[31:20]};
          end
          OP_JALR: begin
            we      = 1'b1;
            save_pc = 1'b1;
            use_imm = 1'b1;
            bsel    = BR_JALR;
            imm32   = {{20{instr[31]}}, instr[31:20]};
          end
          OP_S: begin
            use_imm = 1'b1;
            rs2_en  = 1'b1;
            mw      = f3;
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          end
          OP_B: begin
            rs2_en = 1'b1;
            alu    = (f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
            imm32  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            case (f3)
              3'b000:         bsel = BR_EQ;
              3'b001:         bsel = BR_NE;
              3'b100, 3'b110: bsel = BR_LT;
              3'b101, 3'b111: bsel = BR_GE;
              default:        bsel = BR_NONE;
            endcase
          end
          OP_LUI, OP_AUIPC: begin
            we      = 1'b1;
            save_pc = (opcode == OP_AUIPC);
            use_imm = 1'b1;
            rs1_en  = 1'b0;
            imm32   = {instr[31:12], 12'd0};
          end
          OP_JAL: begin
            we      = 1'b1;
            save_pc = 1'b1;
            use_imm = 1'b1;
            rs1_en  = 1'b0;
            bsel    = BR_JAL;
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          end
          default: begin
            legal  = 1'b0;
            rs1_en = 1'b0;
          end
        endcase
      end

      // Invalid or illegal lanes contribute nothing, neither to outputs nor to hazard detection.
      assign live = in_lane_valid[gi] & legal;
      assign dec_pc[XLEN*gi +: XLEN] = in_lane_valid[gi] ? in_pc[XLEN*gi +: XLEN] : '0;
      assign dec_cw[26*gi +: 26] = live ?
          {(we ? rd : 5'd0), rs2, (rs1_en ? rs1 : 5'd0), alu, we, save_pc, load, use_imm, mw} : '0;
      assign dec_bsel[3*gi +: 3]       = live ? bsel : 3'b000;
      assign dec_imm[XLEN*gi +: XLEN]  = live ? {{(XLEN-31){imm32[31]}}, imm32[30:0]} : '0;
      assign dec_ill[gi]               = in_lane_valid[gi] & ~legal;
      assign prod[gi]                  = live & we & (rd != 5'd0);
      assign use1[gi]                  = live & rs1_en;
      assign use2[gi]                  = live & rs2_en;
      assign prod_rd[REG_ADDR_W*gi +: REG_ADDR_W] = REG_ADDR_W'(rd);
      assign src1[REG_ADDR_W*gi +: REG_ADDR_W]    = REG_ADDR_W'(rs1);
      assign src2[REG_ADDR_W*gi +: REG_ADDR_W]    = REG_ADDR_W'(rs2);
    end

    for (gi = 0; gi < LANES; gi++) begin : g_dep
      logic d;
      always_comb begin
        d = 1'b0;
        for (int i = 0; i < gi; i++) begin
          if (prod[i] &&
              ((use1[gi] && prod_rd[REG_ADDR_W*i +: REG_ADDR_W] == src1[REG_ADDR_W*gi +: REG_ADDR_W]) ||
               (use2[gi] && prod_rd[REG_ADDR_W*i +: REG_ADDR_W] == src2[REG_ADDR_W*gi +: REG_ADDR_W])))
            d = 1'b1;
        end
      end
      assign dec_dep[gi] = d;
    end
  endgenerate

  assign dec_bundle = {in_lane_valid, dec_pc, dec_cw, dec_bsel, dec_imm, dec_ill, dec_dep};

  logic [BW-1:0] o_reg;
  logic [BW-1:0] s_reg;
  logic          o_valid_reg;
  logic          s_valid_reg;
  logic          accept;
  logic          pop;

  // A bundle with no valid lane is consumed but never reaches the output.
  assign accept   = in_valid & in_ready & (|in_lane_valid);
  assign pop      = o_valid_reg & out_ready;
  assign in_ready = ~s_valid_reg;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      o_valid_reg <= 1'b0;
      s_valid_reg <= 1'b0;
      o_reg       <= '0;
      s_reg       <= '0;
    end else if (s_valid_reg && pop) begin
      o_reg       <= s_reg;
      s_valid_reg <= 1'b0;
    end else if (accept && (!o_valid_reg || pop)) begin
      o_reg       <= dec_bundle;
      o_valid_reg <= 1'b1;
    end else if (accept) begin
      s_reg       <= dec_bundle;
      s_valid_reg <= 1'b1;
    end else if (pop) begin
      o_valid_reg <= 1'b0;
    end
  end

  assign out_valid = o_valid_reg;
  assign {out_lane_valid, out_pc, out_control_word, out_branch_sel, out_imm, out_illegal, out_dep} = o_reg;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed testbench for rv32i_decode_stage with LANES=2.
module tb_rv32i_decode_stage;
  localparam int LANES = 2;
  localparam int XLEN  = 32;

  localparam logic [31:0] ADD_I   = 32'h002081B3;
  localparam logic [25:0] ADD_CW  = {5'd3, 5'd2, 5'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
  localparam logic [31:0] ADDI_I  = 32'hFFF00293;
  localparam logic [25:0] ADDI_CW = {5'd5, 5'd31, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
  localparam logic [31:0] SW_I    = 32'h00532223;
  localparam logic [25:0] SW_CW   = {5'd0, 5'd5, 5'd6, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};
  localparam logic [31:0] SUB_I   = {7'b0100000, 5'd5, 5'd3, 3'b000, 5'd4, 7'b0110011};
  localparam logic [25:0] SUB_CW  = {5'd4, 5'd5, 5'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
  localparam logic [31:0] SRA_I   = {7'b0100000, 5'd4, 5'd4, 3'b101, 5'd6, 7'b0110011};
  localparam logic [25:0] SRA_CW  = {5'd6, 5'd4, 5'd4, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
  localparam logic [31:0] BLTU_I  = {1'b0, 6'b000000, 5'd2, 5'd1, 3'b110, 4'b0100, 1'b0, 7'b1100011};
  localparam logic [25:0] BLTU_CW = {5'd0, 5'd2, 5'd1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
  localparam logic [31:0] BGE_I   = {1'b1, 6'b111111, 5'd4, 5'd3, 3'b101, 4'b1110, 1'b1, 7'b1100011};
  localparam logic [25:0] BGE_CW  = {5'd0, 5'd4, 5'd3, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
  localparam logic [31:0] JAL_I   = {1'b1, 10'b1111111100, 1'b1, 8'hFF, 5'd1, 7'b1101111};
  localparam logic [25:0] JAL_CW  = {5'd1, 5'd25, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000};
  localparam logic [31:0] JALR_I  = {12'd12, 5'd1, 3'b000, 5'd5, 7'b1100111};
  localparam logic [25:0] JALR_CW = {5'd5, 5'd12, 5'd1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000};
  localparam logic [31:0] LW_I    = {12'd8, 5'd2, 3'b010, 5'd7, 7'b0000011};
  localparam logic [25:0] LW_CW   = {5'd7, 5'd8, 5'd2, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010};

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_valid;
  logic [32*LANES-1:0]   in_instr;
  logic [XLEN*LANES-1:0] in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_valid;
  logic [XLEN*LANES-1:0] out_pc;
  logic [26*LANES-1:0]   out_control_word;
  logic [3*LANES-1:0]    out_branch_sel;
  logic [XLEN*LANES-1:0] out_imm;
  logic [LANES-1:0]      out_illegal;
  logic [LANES-1:0]      out_dep;

  int errors = 0;
  int checks = 0;

  rv32i_decode_stage #(.LANES(LANES), .XLEN(XLEN), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_pc(out_pc), .out_control_word(out_control_word), .out_branch_sel(out_branch_sel),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_dep(out_dep)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1);
    in_valid      = v;
    in_lane_valid = lv;
    in_instr      = {i1, i0};
    in_pc         = {p1, p0};
    if (v) $display("txn lanes=%b instr=%h/%h pc=%h/%h", lv, i0, i1, p0, p1);
  endtask

  // Drives one bundle for one cycle, then returns at the negedge where its result is visible.
  task automatic send(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1);
    @(negedge clk);
    drive(1'b1, lv, i0, i1, p0, p1);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (out_control_word !== '0 || out_pc !== '0 || out_imm !== '0)
      begin errors++; $display("FAIL reset data: cw=%h pc=%h imm=%h expected all 0", out_control_word, out_pc, out_imm); end
  endtask

  task automatic test_add();
    send(2'b01, ADD_I, 32'd0, 32'h100, 32'h104);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add valid: got %b expected 1", out_valid); end
    checks++; if (out_control_word !== {26'd0, ADD_CW})
      begin errors++; $display("FAIL add cw: got %h expected %h", out_control_word, {26'd0, ADD_CW}); end
    checks++; if (out_pc !== {32'd0, 32'h100} || out_lane_valid !== 2'b01)
      begin errors++; $display("FAIL add pc/lanes: got %h/%b expected 0000000000000100/01", out_pc, out_lane_valid); end
    checks++; if (out_branch_sel !== 6'd0 || out_imm !== 64'd0 || out_illegal !== 2'b00)
      begin errors++; $display("FAIL add misc: bsel=%b imm=%h ill=%b expected 0/0/0", out_branch_sel, out_imm, out_illegal); end
  endtask

  task automatic test_addi_sw();
    send(2'b11, ADDI_I, SW_I, 32'h200, 32'h204);
    checks++; if (out_control_word !== {SW_CW, ADDI_CW})
      begin errors++; $display("FAIL addi_sw cw: got %h expected %h", out_control_word, {SW_CW, ADDI_CW}); end
    checks++; if (out_imm !== {32'd4, 32'hFFFFFFFF})
      begin errors++; $display("FAIL addi_sw imm: got %h expected 00000004ffffffff", out_imm); end
    checks++; if (out_dep !== 2'b10) begin errors++; $display("FAIL addi_sw dep: got %b expected 10", out_dep); end
  endtask

  task automatic test_alu();
    send(2'b11, SUB_I, SRA_I, 32'h300, 32'h304);
    checks++; if (out_control_word !== {SRA_CW, SUB_CW})
      begin errors++; $display("FAIL alu cw: got %h expected %h", out_control_word, {SRA_CW, SUB_CW}); end
    checks++; if (out_dep !== 2'b10) begin errors++; $display("FAIL alu dep: got %b expected 10", out_dep); end
  endtask

  task automatic test_branches();
    send(2'b11, BLTU_I, BGE_I, 32'h400, 32'h404);
    checks++; if (out_control_word !== {BGE_CW, BLTU_CW})
      begin errors++; $display("FAIL branch cw: got %h expected %h", out_control_word, {BGE_CW, BLTU_CW}); end
    checks++; if (out_branch_sel !== {3'b101, 3'b100})
      begin errors++; $display("FAIL branch bsel: got %b expected 101100", out_branch_sel); end
    checks++; if (out_imm !== {32'hFFFFFFFC, 32'd8})
      begin errors++; $display("FAIL branch imm: got %h expected fffffffc00000008", out_imm); end
    checks++; if (out_dep !== 2'b00) begin errors++; $display("FAIL branch dep: got %b expected 00", out_dep); end
    send(2'b11, JAL_I, JALR_I, 32'h500, 32'h504);
    checks++; if (out_control_word !== {JALR_CW, JAL_CW})
      begin errors++; $display("FAIL jump cw: got %h expected %h", out_control_word, {JALR_CW, JAL_CW}); end
    checks++; if (out_branch_sel !== {3'b111, 3'b110})
      begin errors++; $display("FAIL jump bsel: got %b expected 111110", out_branch_sel); end
    checks++; if (out_imm !== {32'd12, 32'hFFFFFFF8})
      begin errors++; $display("FAIL jump imm: got %h expected 0000000cfffffff8", out_imm); end
    checks++; if (out_dep !== 2'b10) begin errors++; $display("FAIL jump dep: got %b expected 10", out_dep); end
  endtask

  task automatic test_illegal();
    send(2'b11, LW_I, 32'h0000007F, 32'h600, 32'h604);
    checks++; if (out_illegal !== 2'b10) begin errors++; $display("FAIL illegal flag: got %b expected 10", out_illegal); end
    checks++; if (out_control_word !== {26'd0, LW_CW})
      begin errors++; $display("FAIL illegal cw: got %h expected %h", out_control_word, {26'd0, LW_CW}); end
    checks++; if (out_branch_sel !== 6'd0 || out_imm !== {32'd0, 32'd8})
      begin errors++; $display("FAIL illegal bsel/imm: got %b/%h expected 000000/0000000000000008", out_branch_sel, out_imm); end
  endtask

  task automatic test_invalid_lanes();
    send(2'b10, ADD_I, SUB_I, 32'h700, 32'h704);
    checks++; if (out_pc !== {32'h704, 32'd0} || out_lane_valid !== 2'b10)
      begin errors++; $display("FAIL lane0_off pc/lanes: got %h/%b expected 0000070400000000/10", out_pc, out_lane_valid); end
    checks++; if (out_control_word !== {SUB_CW, 26'd0} || out_dep !== 2'b00)
      begin errors++; $display("FAIL lane0_off cw/dep: got %h/%b expected %h/00", out_control_word, out_dep, {SUB_CW, 26'd0}); end
    send(2'b00, ADD_I, ADD_I, 32'h800, 32'h804);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL empty_bundle valid/ready: got %b/%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'h1000, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc[31:0] !== 32'h1000 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp A: valid=%b pc=%h ready=%b expected 1/00001000/1", out_valid, out_pc[31:0], in_ready); end
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'h2000, 32'd0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_pc[31:0] !== 32'h1000)
      begin errors++; $display("FAIL bp full: ready=%b pc=%h expected 0/00001000", in_ready, out_pc[31:0]); end
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'h3000, 32'd0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc[31:0] !== 32'h1000 || out_control_word !== {26'd0, ADD_CW})
      begin errors++; $display("FAIL bp stable: ready=%b valid=%b pc=%h cw=%h", in_ready, out_valid, out_pc[31:0], out_control_word); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc[31:0] !== 32'h2000 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp B: valid=%b pc=%h ready=%b expected 1/00002000/1", out_valid, out_pc[31:0], in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc[31:0] !== 32'h3000)
      begin errors++; $display("FAIL bp C: valid=%b pc=%h expected 1/00003000", out_valid, out_pc[31:0]); end
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'h4000, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc[31:0] !== 32'h4000)
      begin errors++; $display("FAIL stream D: valid=%b pc=%h expected 1/00004000", out_valid, out_pc[31:0]); end
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'h5000, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc[31:0] !== 32'h5000)
      begin errors++; $display("FAIL stream E: valid=%b pc=%h expected 1/00005000", out_valid, out_pc[31:0]); end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drain: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'hA000, 32'd0);
    @(negedge clk);
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'hB000, 32'd0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush prefill ready: got %b expected 0", in_ready); end
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'hC000, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush full: valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush leak: got %0d bundles expected 0", seen); end
    drive(1'b1, 2'b01, ADD_I, 32'd0, 32'hD000, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush accept: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'b11, ADDI_I, SW_I, 32'hE000, 32'hE004);
    @(negedge clk);
    drive(1'b1, 2'b11, JAL_I, JALR_I, 32'hF000, 32'hF004);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL midreset valid/ready: got %b/%b expected 0/1", out_valid, in_ready); end
    checks++; if (out_control_word !== '0 || out_pc !== '0 || out_imm !== '0 || out_lane_valid !== '0 || out_dep !== '0)
      begin errors++; $display("FAIL midreset data: cw=%h pc=%h imm=%h lanes=%b dep=%b expected all 0",
                               out_control_word, out_pc, out_imm, out_lane_valid, out_dep); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi_sw();
    test_alu();
    test_branches();
    test_illegal();
    test_invalid_lanes();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Parametrised, multi-lane, registered successor to the single-instruction RV32I combinational decoder.
- Each cycle it accepts a bundle of LANES instructions with their PCs over a valid/ready handshake and decodes every lane.
- Per lane it produces the 26-bit control word, branch select, sign-extended immediate, an illegal-opcode flag and an intra-bundle RAW dependency flag.
- Sits between fetch and issue/regfile read, with a skid buffer so that back-pressure costs no throughput.

Parameters:
- LANES, 2, instructions per bundle (1..4).
- XLEN, 32, PC and immediate width.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and in-flight bundles
- in_valid  in  1  input bundle valid
- in_ready  out  1  stage can accept a bundle
- in_lane_valid  in  LANES  per-lane valid; lane 0 is oldest
- in_instr  in  32*LANES  instructions; lane k at [32k+31:32k]
- in_pc  in  XLEN*LANES  PCs
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_lane_valid  out  LANES
- out_pc  out  XLEN*LANES
- out_control_word  out  26*LANES
- out_branch_sel  out  3*LANES
- out_imm  out  XLEN*LANES
- out_illegal  out  LANES
- out_dep  out  LANES

Behaviour:
- Reset: synchronous, active-high. All outputs and the skid register clear to 0, except in_ready, which is 1 from the first cycle after reset.

Control word fields:
- [25:21] rd; 0 when we=0.
- [20:16] rs2 = instr[24:20].
- [15:11] rs1 = instr[19:15]; 0 for LUI/AUIPC/JAL.
- [10:7] ALU function.
- [6] we: R, I, U or J type.
- [5] save_pc: JAL, JALR, AUIPC.
- [4] load.
- [3] use_imm: I, S, U or J type.
- [2:0] mem width = func3 for load/store, else 0.

ALU function encoding:
- ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 1000, SRA 1001, SRL 1010.
- R-type func3=000 uses instr[30] to select SUB; I-type is always ADD.
- Load, JALR, store, LUI, AUIPC and JAL use ADD.
- Branches use SLTU for func3=11x, otherwise SUB.

Branch select encoding:
- 000 none, 010 BEQ, 011 BNE, 100 BLT/BLTU, 101 BGE/BGEU, 110 JAL, 111 JALR.
- A B-type instruction with func3 010 or 011 decodes to 000.

Immediate:
- Standard RV32I I/S/B/U/J formats, sign-extended to XLEN.
- 0 for R-type and illegal instructions.

Illegal instructions:
- An opcode outside {0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111} sets out_illegal.
- The lane's control word, branch select and immediate are then all 0.

Dependency flag:
- out_dep[j]=1 if some valid lane i<j has we=1, rd≠0 and rd equal to lane j's rs1 (when rs1 is used) or rs2 (when rs2 is used).
- rs2 is used only for R, S and B types.
- out_dep[0] is always 0.

Invalid lanes:
- A lane with in_lane_valid=0 produces all-zero decoded outputs, including out_pc.

Handshake and buffering (one output register O, one skid register S):
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~S_valid (registered, no combinational path from out_ready).
- If S_valid & pop: O<=S, S_valid<=0.
- Else if accept & (~O_valid | pop): O<=decode(in).
- Else if accept: S<=decode(in), S_valid<=1.
- Else if pop: O_valid<=0.
- A bundle with in_lane_valid==0 is accepted and discarded (no output).
- Latency is 1 cycle from accept to out_valid; sustained throughput is 1 bundle/cycle.
- While out_valid=1 and out_ready=0, every out_* signal stays stable.

Flush:
- Next cycle: O_valid=0, S_valid=0, in_ready=1.
- A bundle accepted in the flush cycle is dropped.
- flush has priority over accept and pop.
- Reset has priority over flush.

Test Plan:
- Single-lane `add x3,x1,x2` (0x002081B3), pc 0x100, out_ready=1 -> after 1 cycle: control_word={3,2,1,0000,1,0,0,0,000}, branch_sel 000, imm 0, illegal 0.
- LANES=2: lane0 `addi x5,x0,-1` (0xFFF00293), lane1 `sw x5,4(x6)` (0x00532223) -> imm0=0xFFFFFFFF, imm1=4, lane1 we=0, rd field 0, mem width 010, out_dep=10b.
- Branch/jump set: `bltu` -> branch_sel 100 with ALU 0011; `bge` -> 101 with ALU 0001; `jal x1,-8` -> branch_sel 110, imm 0xFFFFFFF8, rs1 field 0, save_pc=1; `jalr` -> 111.
- Back-pressure: 3 back-to-back bundles with out_ready=0 -> in_ready drops after the 2nd accept, outputs stay stable; then out_ready=1 -> all 3 bundles delivered in order, none lost or duplicated.
- Illegal opcode 0x0000007F in lane1 -> out_illegal=10b, lane1 control word, branch_sel and imm all 0, lane0 decoded normally.
- Flush with O and S full while in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed bundles never appear at the output. Reset asserted mid-stream -> all outputs 0.
